// File: rtl/descrambler_frame_ctrl.sv
// Frame sequencer for the 16-bit I/Q descrambler: LFSR reseed per frame, sample gating, output FIFO.
// Optional statistics counters (stat_frames, stat_drops) when DSC_CTRL_STATS_EN is defined.
module descrambler_frame_ctrl #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DS_LAT     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] cfg_frame_len,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [15:0]      s_data,
  output logic             ds_seed_load,
  output logic             ds_en,
  output logic [15:0]      ds_inp,
  input  logic [15:0]      ds_outp,
  input  logic             ds_valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic             m_last,
  output logic             busy,
  output logic             frame_done,
  output logic             err_sof
`ifdef DSC_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_drops
`endif
);

  // state    | meaning
  // IDLE     | disarmed, waiting for cfg_start
  // WAIT_SOF | accepting and dropping samples until one carries s_sof
  // SEED     | descrambler reloading; held SOF sample is enabled this cycle
  // RUN      | mid-frame, one descrambler enable per accepted sample
  typedef enum logic [1:0] {IDLE, WAIT_SOF, SEED, RUN} state_t;

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = $clog2(DS_LAT + 1);

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   frame_len, cnt, cnt_inc;
  logic [15:0]        sof_hold;
  logic [DS_LAT-1:0]  en_pipe, last_pipe;
  logic [IF_W-1:0]    inflight;
  logic [CNT_W:0]     occ;
  logic               space, last_hit, use_hold, push, pop;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [15:0]        mem_data [FIFO_DEPTH];
  logic               mem_last [FIFO_DEPTH];

  // Results still inside the descrambler must already own a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < DS_LAT; i++) inflight = inflight + IF_W'(en_pipe[i]);
    occ   = {1'b0, fifo_count} + (CNT_W+1)'(inflight);
    space = (occ <= (CNT_W+1)'(FIFO_DEPTH - 1));
  end

  assign cnt_inc  = (state == SEED) ? LEN_W'(1) : cnt + LEN_W'(1);
  assign last_hit = (cnt_inc == frame_len);

  always_comb begin
    state_nxt    = state;
    s_ready      = 1'b0;
    ds_en        = 1'b0;
    ds_seed_load = 1'b0;
    use_hold     = 1'b0;
    case (state)
      IDLE: if (cfg_start && cfg_frame_len != '0) state_nxt = WAIT_SOF;
      WAIT_SOF: begin
        s_ready = space;
        if (s_valid && space && s_sof) begin
          ds_seed_load = 1'b1;
          state_nxt    = SEED;
        end
      end
      SEED: begin
        ds_en     = 1'b1;
        use_hold  = 1'b1;
        state_nxt = last_hit ? WAIT_SOF : RUN;
      end
      RUN: begin
        s_ready = space;
        if (s_valid && space) begin
          ds_en = 1'b1;
          if (last_hit) state_nxt = WAIT_SOF;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (cfg_abort) begin
      state_nxt    = IDLE;
      s_ready      = 1'b0;
      ds_en        = 1'b0;
      ds_seed_load = 1'b0;
    end
  end

  assign ds_inp     = ds_en ? (use_hold ? sof_hold : s_data) : 16'h0000;
  assign frame_done = ds_en & last_hit;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_len <= '0;
      cnt       <= '0;
      sof_hold  <= '0;
      err_sof   <= 1'b0;
      en_pipe   <= '0;
      last_pipe <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cfg_start && !cfg_abort) begin
        frame_len <= cfg_frame_len;
        err_sof   <= 1'b0;
      end
      if (cfg_abort) cnt <= '0;
      else if (ds_en) cnt <= last_hit ? '0 : cnt_inc;
      if (ds_seed_load) sof_hold <= s_data;
      if (state == RUN && ds_en && s_sof) err_sof <= 1'b1;
      if (cfg_abort) begin
        en_pipe   <= '0;
        last_pipe <= '0;
      end else begin
        en_pipe   <= (en_pipe << 1) | DS_LAT'(ds_en);
        last_pipe <= (last_pipe << 1) | DS_LAT'(frame_done);
      end
    end
  end

  // Only results tied to a live enable are stored; aborted ones fall on the floor.
  assign push    = ds_valid & en_pipe[DS_LAT-1];
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid & m_ready;
  assign m_data  = mem_data[rd_ptr];
  assign m_last  = mem_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_last[i] <= 1'b0;
      end
    end else if (cfg_abort) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= ds_outp;
        mem_last[wr_ptr] <= last_pipe[DS_LAT-1];
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop) fifo_count <= fifo_count + CNT_W'(1);
      else if (pop && !push) fifo_count <= fifo_count - CNT_W'(1);
    end
  end

`ifdef DSC_CTRL_STATS_EN
  logic drop;
  assign drop = (state == WAIT_SOF) && s_valid && s_ready && !s_sof;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_drops  <= '0;
    end else begin
      if (frame_done) stat_frames <= stat_frames + 16'd1;
      if (drop && stat_drops != 16'hFFFF) stat_drops <= stat_drops + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_descrambler_frame_ctrl.sv
// Bench for descrambler_frame_ctrl: table of frame scenarios plus a scoreboard of expected outputs
// fed by a golden descrambler model; hand sequences cover latency, abort and mid-frame reset.
module tb_descrambler_frame_ctrl;

  logic        clk, rst_n;
  logic [15:0] cfg_frame_len;
  logic        cfg_start, cfg_abort;
  logic        s_valid, s_ready, s_sof;
  logic [15:0] s_data;
  logic        ds_seed_load, ds_en;
  logic [15:0] ds_inp, ds_outp;
  logic        ds_valid;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic        m_last, busy, frame_done, err_sof;
`ifdef DSC_CTRL_STATS_EN
  logic [15:0] stat_frames, stat_drops;
`endif

  descrambler_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cfg_frame_len(cfg_frame_len), .cfg_start(cfg_start),
    .cfg_abort(cfg_abort), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .s_data(s_data), .ds_seed_load(ds_seed_load), .ds_en(ds_en), .ds_inp(ds_inp),
    .ds_outp(ds_outp), .ds_valid(ds_valid), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .frame_done(frame_done), .err_sof(err_sof)
`ifdef DSC_CTRL_STATS_EN
    , .stat_frames(stat_frames), .stat_drops(stat_drops)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] x_step(input logic [17:0] x);
    return {x[0] ^ x[7], x[17:1]};
  endfunction
  function automatic logic [17:0] y_step(input logic [17:0] y);
    return {y[0] ^ y[5] ^ y[7] ^ y[10], y[17:1]};
  endfunction

  // Stand-in for the external descrambler, en->valid latency of one cycle.
  logic [17:0] dx, dy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dx <= 18'h00001; dy <= 18'h3ffff; ds_valid <= 1'b0; ds_outp <= 16'h0;
    end else begin
      ds_valid <= ds_en;
      if (ds_seed_load) begin
        dx <= 18'h00001; dy <= 18'h3ffff;
      end else if (ds_en) begin
        ds_outp <= ds_inp ^ (dx[15:0] ^ dy[15:0]);
        dx <= x_step(dx); dy <= y_step(dy);
      end
    end
  end

  int rdy_mode = 0;
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = ~m_ready;
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  typedef struct packed { logic [15:0] d; logic l; } exp_t;
  exp_t q[$];
  bit          g_in_frame;
  int          g_cnt, g_len;
  logic [17:0] gx, gy;
  int          seeds_seen, en_seen, done_seen;

  task automatic model_clear();
    q.delete();
    g_in_frame = 0;
    g_cnt = 0;
  endtask

  // Golden frame model and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ds_seed_load) seeds_seen++;
      if (ds_en) en_seen++;
      if (frame_done) done_seen++;
      if (s_valid && s_ready) begin
        if (!g_in_frame && s_sof) begin
          g_in_frame = 1; g_cnt = 0; gx = 18'h00001; gy = 18'h3ffff;
        end
        if (g_in_frame) begin
          g_cnt++;
          e.d = s_data ^ (gx[15:0] ^ gy[15:0]);
          e.l = (g_cnt == g_len);
          q.push_back(e);
          gx = x_step(gx); gy = y_step(gy);
          if (g_cnt == g_len) g_in_frame = 0;
        end
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("out_queued", 0, 1);
        else begin
          e = q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.l);
        end
      end
    end
  end

  task automatic pulse_abort();
    @(posedge clk); #1 cfg_abort = 1'b1;
    @(posedge clk); #1 cfg_abort = 1'b0;
    model_clear();
  endtask

  task automatic start(input int len);
    g_len = len;
    @(posedge clk); #1 cfg_frame_len = 16'(len); cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
  endtask

  task automatic drive_sample(input logic [15:0] d, input bit sof);
    bit hs = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge clk); hs = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_sof = 1'b0;
    if (!hs) chk("accept_timeout", 0, 1);
  endtask

  typedef struct {
    int len; int nsamp; logic [31:0] sof_mask; int rmode; int gaps;
    int seeds; int frames; int err; int drops;
  } row_t;
  row_t rows[6];

  task automatic run_row(input row_t r);
    int gap;
`ifdef DSC_CTRL_STATS_EN
    logic [15:0] f0, d0;
`endif
    rdy_mode = r.rmode;
    pulse_abort();
    seeds_seen = 0; en_seen = 0; done_seen = 0;
`ifdef DSC_CTRL_STATS_EN
    f0 = stat_frames; d0 = stat_drops;
`endif
    start(r.len);
    for (int i = 0; i < r.nsamp; i++) begin
      drive_sample(16'($urandom), r.sof_mask[i]);
      gap = r.gaps ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
    for (int c = 0; c < 400 && q.size() != 0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);
    chk("fifo_empty", m_valid, 0);
    chk("seed_pulses", seeds_seen, r.seeds);
    chk("frame_done_cnt", done_seen, r.frames);
    chk("ds_en_cnt", en_seen, r.nsamp - r.drops);
    chk("err_sof", err_sof, r.err);
    chk("busy_wait_sof", busy, 1);
`ifdef DSC_CTRL_STATS_EN
    chk("stat_frames", stat_frames - f0, r.frames);
    chk("stat_drops", stat_drops - d0, r.drops);
`endif
  endtask

  initial begin
    rows[0] = '{len:4, nsamp:8, sof_mask:32'h11, rmode:0, gaps:0, seeds:2, frames:2, err:0, drops:0};
    rows[1] = '{len:4, nsamp:8, sof_mask:32'h11, rmode:1, gaps:0, seeds:2, frames:2, err:0, drops:0};
    rows[2] = '{len:4, nsamp:7, sof_mask:32'h08, rmode:0, gaps:0, seeds:1, frames:1, err:0, drops:3};
    rows[3] = '{len:6, nsamp:6, sof_mask:32'h05, rmode:0, gaps:0, seeds:1, frames:1, err:1, drops:0};
    rows[4] = '{len:1, nsamp:4, sof_mask:32'h0F, rmode:0, gaps:0, seeds:4, frames:4, err:0, drops:0};
    rows[5] = '{len:3, nsamp:6, sof_mask:32'h09, rmode:2, gaps:1, seeds:2, frames:2, err:0, drops:0};

    rst_n = 1'b0; cfg_frame_len = '0; cfg_start = 1'b0; cfg_abort = 1'b0;
    s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    model_clear(); g_len = 0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ds_ctl", {ds_en, ds_seed_load, frame_done, err_sof, m_last}, 0);
    chk("rst_data", {ds_inp, m_data}, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_row(rows[i]);

    // Zero length and abort-over-start both leave the controller idle.
    rdy_mode = 3;
    pulse_abort();
    start(0);
    chk("len0_idle", busy, 0);
    @(posedge clk); #1 cfg_frame_len = 16'd3; cfg_start = 1'b1; cfg_abort = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("abort_wins", busy, 0);

    // Seed timing, first-word latency, then abort with data buffered and in flight.
    done_seen = 0;
    start(3);
    @(posedge clk); #1 s_valid = 1'b1; s_sof = 1'b1; s_data = 16'hA5C3;
    @(negedge clk);
    chk("sof_ready", s_ready, 1);
    chk("seed_pulse", {ds_seed_load, ds_en}, 2'b10);
    @(posedge clk); #1 s_valid = 1'b0; s_sof = 1'b0;
    @(negedge clk);
    chk("seed_en", {ds_en, s_ready, ds_seed_load}, 3'b100);
    chk("seed_inp", ds_inp, 16'hA5C3);
    chk("lat_m_valid_0", m_valid, 0);
    @(negedge clk);
    chk("lat_m_valid_1", m_valid, 0);
    @(negedge clk);
    chk("lat_m_valid_2", m_valid, 1);
    @(posedge clk); #1;
    drive_sample(16'h1234, 1'b0);
    cfg_abort = 1'b1;
    @(negedge clk);
    chk("abort_s_ready", s_ready, 0);
    @(posedge clk); #1 cfg_abort = 1'b0;
    model_clear();
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("abort_no_late", m_valid, 0);
    chk("abort_no_done", done_seen, 0);
    run_row(rows[0]);

    // Asynchronous reset in the middle of a frame.
    rdy_mode = 3;
    pulse_abort();
    start(4);
    drive_sample(16'hBEEF, 1'b1);
    drive_sample(16'h0F0F, 1'b0);
    drive_sample(16'h7001, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m_valid", m_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_s_ready", s_ready, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_after", {m_valid, busy}, 0);
    run_row(rows[4]);
    run_row(rows[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
